// File: rtl/processor_pkg.sv
// Shared opcode, state and ALU encodings for the Lab B processor.
// Imported by the control unit, datapath, IR and benches.
package processor_pkg;

    localparam logic [3:0] OP_NOOP  = 4'd0;
    localparam logic [3:0] OP_STORE = 4'd1;
    localparam logic [3:0] OP_LOAD  = 4'd2;
    localparam logic [3:0] OP_ADD   = 4'd3;
    localparam logic [3:0] OP_SUB   = 4'd4;
    localparam logic [3:0] OP_HALT  = 4'd5;

    typedef enum logic [3:0] {
        S_INIT   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_NOOP   = 4'd3,
        S_LOAD_A = 4'd4,
        S_LOAD_B = 4'd5,
        S_STORE  = 4'd6,
        S_ADD    = 4'd7,
        S_SUB    = 4'd8,
        S_HALT   = 4'd9
    } state_t;

    localparam logic [2:0] ALU_PASS = 3'd0;
    localparam logic [2:0] ALU_ADD  = 3'd1;
    localparam logic [2:0] ALU_SUB  = 3'd2;

endpackage

// File: rtl/control_unit.sv
// Moore sequencer for the Lab B datapath: fetch, decode, execute.
// State register is the only storage; outputs depend on state and IR.
module control_unit
    import processor_pkg::*;
#(
    parameter int OP_W   = 4,
    parameter int ADDR_W = 8
) (
    input  logic              clock,
    input  logic              clear,
    input  logic [15:0]       instruction,
    output logic              pc_clr,
    output logic              pc_up,
    output logic              ir_clr,
    output logic              ir_ld,
    output logic [ADDR_W-1:0] d_addr,
    output logic              d_wr,
    output logic              rf_s,
    output logic [3:0]        rf_ra_addr,
    output logic [3:0]        rf_rb_addr,
    output logic [3:0]        rf_w_addr,
    output logic              rf_w_wr,
    output logic [2:0]        alu_s0,
    output logic [3:0]        state
);

    state_t st_q;
    state_t st_d;

    logic [OP_W-1:0] op;

    assign op    = instruction[15:16-OP_W];
    assign state = st_q;

    always_ff @(posedge clock) begin
        if (clear)
            st_q <= S_INIT;
        else
            st_q <= st_d;
    end

    always_comb begin
        st_d       = st_q;
        pc_clr     = 1'b0;
        pc_up      = 1'b0;
        ir_clr     = 1'b0;
        ir_ld      = 1'b0;
        d_addr     = '0;
        d_wr       = 1'b0;
        rf_s       = 1'b0;
        rf_ra_addr = 4'd0;
        rf_rb_addr = 4'd0;
        rf_w_addr  = 4'd0;
        rf_w_wr    = 1'b0;
        alu_s0     = ALU_PASS;

        unique case (st_q)
            S_INIT: begin
                pc_clr = 1'b1;
                ir_clr = 1'b1;
                st_d   = S_FETCH;
            end
            S_FETCH: begin
                ir_ld = 1'b1;
                pc_up = 1'b1;
                st_d  = S_DECODE;
            end
            S_DECODE: begin
                // Unassigned opcodes fall through to NOOP
                unique case (1'b1)
                    op == OP_STORE: st_d = S_STORE;
                    op == OP_LOAD:  st_d = S_LOAD_A;
                    op == OP_ADD:   st_d = S_ADD;
                    op == OP_SUB:   st_d = S_SUB;
                    op == OP_HALT:  st_d = S_HALT;
                    default:        st_d = S_NOOP;
                endcase
            end
            S_NOOP: begin
                st_d = S_FETCH;
            end
            S_LOAD_A: begin
                d_addr    = instruction[11:4];
                rf_s      = 1'b1;
                rf_w_addr = instruction[3:0];
                st_d      = S_LOAD_B;
            end
            S_LOAD_B: begin
                d_addr    = instruction[11:4];
                rf_s      = 1'b1;
                rf_w_addr = instruction[3:0];
                rf_w_wr   = 1'b1;
                st_d      = S_FETCH;
            end
            S_STORE: begin
                d_addr     = instruction[7:0];
                rf_ra_addr = instruction[11:8];
                alu_s0     = ALU_PASS;
                d_wr       = 1'b1;
                st_d       = S_FETCH;
            end
            S_ADD: begin
                rf_ra_addr = instruction[11:8];
                rf_rb_addr = instruction[7:4];
                rf_w_addr  = instruction[3:0];
                alu_s0     = ALU_ADD;
                rf_w_wr    = 1'b1;
                st_d       = S_FETCH;
            end
            S_SUB: begin
                rf_ra_addr = instruction[11:8];
                rf_rb_addr = instruction[7:4];
                rf_w_addr  = instruction[3:0];
                alu_s0     = ALU_SUB;
                rf_w_wr    = 1'b1;
                st_d       = S_FETCH;
            end
            S_HALT: begin
                st_d = S_HALT;
            end
            default: begin
                st_d = S_INIT;
            end
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// Randomized bench for control_unit against an instruction-level model.
// The bench also plays the instruction register.
module tb_control_unit;
    import processor_pkg::*;

    logic        clock;
    logic        clear;
    logic [15:0] instruction;
    logic        pc_clr;
    logic        pc_up;
    logic        ir_clr;
    logic        ir_ld;
    logic [7:0]  d_addr;
    logic        d_wr;
    logic        rf_s;
    logic [3:0]  rf_ra_addr;
    logic [3:0]  rf_rb_addr;
    logic [3:0]  rf_w_addr;
    logic        rf_w_wr;
    logic [2:0]  alu_s0;
    logic [3:0]  state;

    control_unit #(.OP_W(4), .ADDR_W(8)) dut (
        .clock       (clock),
        .clear       (clear),
        .instruction (instruction),
        .pc_clr      (pc_clr),
        .pc_up       (pc_up),
        .ir_clr      (ir_clr),
        .ir_ld       (ir_ld),
        .d_addr      (d_addr),
        .d_wr        (d_wr),
        .rf_s        (rf_s),
        .rf_ra_addr  (rf_ra_addr),
        .rf_rb_addr  (rf_rb_addr),
        .rf_w_addr   (rf_w_addr),
        .rf_w_wr     (rf_w_wr),
        .alu_s0      (alu_s0),
        .state       (state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Model: where we are within the current instruction
    localparam int M_NONE = -1;
    localparam int M_INIT = 0;
    localparam int M_FETCH = 1;
    localparam int M_DEC = 2;
    localparam int M_EXEC = 3;
    localparam int M_HALT = 4;

    int mode = M_NONE;
    int kind = 0;
    int step = 0;

    logic [15:0] prog[$];

    function automatic logic [15:0] prog_next();
        logic [15:0] v;
        if (prog.size() > 0) begin
            v = prog.pop_front();
        end else begin
            v = 16'($urandom);
        end
        return v;
    endfunction

    // {state, pc_clr, pc_up, ir_clr, ir_ld, d_addr, d_wr,
    //  rf_s, ra, rb, wa, w_wr, alu}
    function automatic logic [33:0] model_vec(logic [15:0] ins);
        logic [3:0] st;
        logic pcc, pcu, irc, irl, dw, rs, ww;
        logic [7:0] da;
        logic [3:0] ra, rb, wa;
        logic [2:0] al;
        st = 0; pcc = 0; pcu = 0; irc = 0; irl = 0;
        dw = 0; rs = 0; ww = 0; da = 0;
        ra = 0; rb = 0; wa = 0; al = 0;
        case (mode)
            M_INIT:  begin st = 0; pcc = 1; irc = 1; end
            M_FETCH: begin st = 1; irl = 1; pcu = 1; end
            M_DEC:   st = 2;
            M_HALT:  st = 9;
            default: begin
                case (kind)
                    2: begin
                        st = 4'(4 + step);
                        da = ins[11:4]; rs = 1;
                        wa = ins[3:0]; ww = (step == 1);
                    end
                    1: begin
                        st = 6; da = ins[7:0];
                        ra = ins[11:8]; dw = 1;
                    end
                    3, 4: begin
                        st = (kind == 3) ? 4'd7 : 4'd8;
                        ra = ins[11:8]; rb = ins[7:4];
                        wa = ins[3:0]; ww = 1;
                        al = (kind == 3) ? 3'd1 : 3'd2;
                    end
                    default: st = 3;
                endcase
            end
        endcase
        return {st, pcc, pcu, irc, irl, da, dw, rs,
                ra, rb, wa, ww, al};
    endfunction

    task automatic advance(input logic c);
        int op;
        if (c) begin
            mode = M_INIT;
        end else begin
            case (mode)
                M_INIT:  mode = M_FETCH;
                M_FETCH: mode = M_DEC;
                M_DEC: begin
                    op = int'(instruction[15:12]);
                    if (op == 5) begin
                        mode = M_HALT;
                    end else begin
                        mode = M_EXEC;
                        step = 0;
                        kind = (op >= 1 && op <= 4) ? op : 0;
                    end
                end
                M_EXEC: begin
                    if (kind == 2 && step == 0) step = 1;
                    else mode = M_FETCH;
                end
                default: ;
            endcase
        end
    endtask

    task automatic check_cycle();
        logic [33:0] exp_v;
        logic [33:0] act_v;
        exp_v = model_vec(instruction);
        act_v = {state, pc_clr, pc_up, ir_clr, ir_ld, d_addr,
                 d_wr, rf_s, rf_ra_addr, rf_rb_addr,
                 rf_w_addr, rf_w_wr, alu_s0};
        checks++;
        if (act_v !== exp_v) begin
            errors++;
            $display("FAIL outputs ir=%h actual %h expected %h",
                     instruction, act_v, exp_v);
        end
        checks++;
        if (d_wr && rf_w_wr) begin
            errors++;
            $display("FAIL write_excl actual d_wr=%b rf_w_wr=%b expected at most one",
                     d_wr, rf_w_wr);
        end
    endtask

    task automatic tick(input logic c);
        @(negedge clock);
        if (mode != M_NONE) check_cycle();
        clear = c;
        if (mode == M_FETCH) instruction = prog_next();
        else if (mode == M_INIT) instruction = 16'h0000;
        @(posedge clock);
        advance(c);
    endtask

    task automatic lit(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s actual %0h expected %0h",
                     name, act, exp_v);
        end
    endtask

    initial begin
        clear = 1'b1;
        instruction = 16'h0000;
        prog.push_back(16'h3123);
        prog.push_back(16'h21B5);
        prog.push_back(16'h1A80);
        prog.push_back(16'hF000);
        prog.push_back(16'h5000);

        tick(1);
        #1;
        lit("rst_state", 32'(state), 0);
        lit("rst_pc_clr", 32'(pc_clr), 1);
        lit("rst_ir_clr", 32'(ir_clr), 1);
        lit("rst_ir_ld", 32'(ir_ld), 0);

        tick(0);
        #1;
        lit("fetch_state", 32'(state), 1);
        lit("fetch_ir_ld", 32'(ir_ld), 1);
        lit("fetch_pc_up", 32'(pc_up), 1);

        tick(0);
        tick(0);
        #1;
        lit("add_state", 32'(state), 7);
        lit("add_ra", 32'(rf_ra_addr), 1);
        lit("add_rb", 32'(rf_rb_addr), 2);
        lit("add_wa", 32'(rf_w_addr), 3);
        lit("add_alu", 32'(alu_s0), 1);
        lit("add_wwr", 32'(rf_w_wr), 1);
        tick(0);
        #1;
        lit("add_refetch", 32'(state), 1);

        tick(0);
        tick(0);
        #1;
        lit("lda_state", 32'(state), 4);
        lit("lda_addr", 32'(d_addr), 32'h1B);
        lit("lda_rf_s", 32'(rf_s), 1);
        lit("lda_wa", 32'(rf_w_addr), 5);
        lit("lda_wwr", 32'(rf_w_wr), 0);
        tick(0);
        #1;
        lit("ldb_state", 32'(state), 5);
        lit("ldb_wwr", 32'(rf_w_wr), 1);
        tick(0);
        #1;
        lit("ld_refetch", 32'(state), 1);

        tick(0);
        tick(0);
        #1;
        lit("st_state", 32'(state), 6);
        lit("st_addr", 32'(d_addr), 32'h80);
        lit("st_ra", 32'(rf_ra_addr), 32'hA);
        lit("st_d_wr", 32'(d_wr), 1);
        tick(0);
        #1;
        lit("st_d_wr_off", 32'(d_wr), 0);

        tick(0);
        tick(0);
        #1;
        lit("f000_noop", 32'(state), 3);

        tick(0);
        tick(0);
        tick(0);
        #1;
        lit("halt_state", 32'(state), 9);
        instruction = 16'hF000;
        repeat (10) tick(0);
        #1;
        lit("halt_stay", 32'(state), 9);
        lit("halt_ir_ld", 32'(ir_ld), 0);
        tick(1);
        #1;
        lit("halt_clear", 32'(state), 0);

        prog.push_back(16'h21B5);
        tick(0);
        tick(0);
        tick(0);
        #1;
        lit("midld_lda", 32'(state), 4);
        tick(1);
        #1;
        lit("midld_init", 32'(state), 0);
        lit("midld_wwr", 32'(rf_w_wr), 0);

        repeat (3000) tick($urandom_range(0, 39) == 0);
        @(negedge clock);
        check_cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
